// File: rtl/ide_sector_engine_if.sv
// Bus bundle for ide_sector_engine: command, byte streams, IDE register bus.
// slave = engine side; master = CPU buffer plus drive side.
interface ide_sector_engine_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [23:0] cmd_lba;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        done;
  logic        error;
  logic        ide_ce_n;
  logic        ide_oe_n;
  logic        ide_we_n;
  logic [2:0]  ide_addr;
  logic [7:0]  ide_dout;
  logic [7:0]  ide_din;

  modport slave (
    input  cmd_valid, cmd_write, cmd_lba,
    input  rd_ready, wr_data, wr_valid, ide_din,
    output cmd_ready, rd_data, rd_valid, wr_ready,
    output done, error,
    output ide_ce_n, ide_oe_n, ide_we_n, ide_addr, ide_dout
  );

  modport master (
    output cmd_valid, cmd_write, cmd_lba,
    output rd_ready, wr_data, wr_valid, ide_din,
    input  cmd_ready, rd_data, rd_valid, wr_ready,
    input  done, error,
    input  ide_ce_n, ide_oe_n, ide_we_n, ide_addr, ide_dout
  );
endinterface

// File: rtl/ide_sector_engine.sv
// IDE task-file sequencer: programs LBA + command, polls status, moves one sector.
// Ports: clk, arst (async, active-high), bus_io (cmd, rd/wr streams, IDE bus).
module ide_sector_engine #(
  parameter int SECTOR_BYTES = 512,
  parameter int POLL_TIMEOUT = 4096
) (
  input logic               clk,
  input logic               arst,
  ide_sector_engine_if.slave bus_io
);

  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [10:0]   NB   = 11'(SECTOR_BYTES);
  localparam logic [PW-1:0] PLST = PW'(POLL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_POLL,
    S_XRD, S_XWR, S_DONE
  } state_t;

  state_t        state_q;
  logic [2:0]    step_q;
  logic          wr_q;
  logic [23:0]   lba_q;
  logic [10:0]   cnt_q;
  logic [PW-1:0] poll_q;
  logic [7:0]    rd_data_q;
  logic          rd_valid_q;
  logic          error_q;

  logic rd_more, rd_pop, rd_take, rd_last, wr_take;
  logic [7:0] din;

  assign din     = bus_io.ide_din;
  assign rd_more = (cnt_q != NB);
  assign rd_pop  = rd_valid_q && bus_io.rd_ready;
  // Fetch the next byte when the holding register is empty or draining now.
  assign rd_take = (state_q == S_XRD) && rd_more &&
                   (!rd_valid_q || bus_io.rd_ready);
  assign rd_last = (state_q == S_XRD) && !rd_more && rd_pop;
  assign wr_take = (state_q == S_XWR) && bus_io.wr_valid;

  // Bus strobes decode straight from state so arst kills them at once.
  always_comb begin
    bus_io.ide_ce_n = 1'b1;
    bus_io.ide_oe_n = 1'b1;
    bus_io.ide_we_n = 1'b1;
    bus_io.ide_addr = 3'd0;
    bus_io.ide_dout = 8'h00;
    unique case (state_q)
      S_SETUP: begin
        bus_io.ide_ce_n = 1'b0;
        bus_io.ide_we_n = 1'b0;
        bus_io.ide_addr = 3'd2 + step_q;
        unique case (step_q)
          3'd0:    bus_io.ide_dout = 8'h01;
          3'd1:    bus_io.ide_dout = lba_q[7:0];
          3'd2:    bus_io.ide_dout = lba_q[15:8];
          3'd3:    bus_io.ide_dout = lba_q[23:16];
          default: bus_io.ide_dout = 8'hE0;
        endcase
      end
      S_CMD: begin
        bus_io.ide_ce_n = 1'b0;
        bus_io.ide_we_n = 1'b0;
        bus_io.ide_addr = 3'd7;
        bus_io.ide_dout = wr_q ? 8'h30 : 8'h20;
      end
      S_POLL: begin
        bus_io.ide_ce_n = 1'b0;
        bus_io.ide_oe_n = 1'b0;
        bus_io.ide_addr = 3'd7;
      end
      S_XRD: begin
        bus_io.ide_ce_n = !rd_take;
        bus_io.ide_oe_n = !rd_take;
      end
      S_XWR: begin
        bus_io.ide_ce_n = !wr_take;
        bus_io.ide_we_n = !wr_take;
        bus_io.ide_dout = wr_take ? bus_io.wr_data : 8'h00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= S_IDLE;
      step_q     <= 3'd0;
      wr_q       <= 1'b0;
      lba_q      <= 24'd0;
      cnt_q      <= 11'd0;
      poll_q     <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      error_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus_io.cmd_valid) begin
            wr_q    <= bus_io.cmd_write;
            lba_q   <= bus_io.cmd_lba;
            step_q  <= 3'd0;
            cnt_q   <= 11'd0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (step_q == 3'd4) state_q <= S_CMD;
          else step_q <= step_q + 3'd1;
        end
        S_CMD: begin
          poll_q  <= '0;
          state_q <= S_POLL;
        end
        S_POLL: begin
          if (din[0]) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (!din[7] && din[3]) begin
            state_q <= wr_q ? S_XWR : S_XRD;
          end else if (poll_q == PLST) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            poll_q <= poll_q + PW'(1);
          end
        end
        S_XRD: begin
          if (rd_take) begin
            rd_data_q  <= din;
            rd_valid_q <= 1'b1;
            cnt_q      <= cnt_q + 11'd1;
          end else if (rd_pop) begin
            rd_valid_q <= 1'b0;
          end
          if (rd_last) state_q <= S_IDLE;
        end
        S_XWR: begin
          if (wr_take) begin
            cnt_q <= cnt_q + 11'd1;
            if (cnt_q == NB - 11'd1) state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_io.cmd_ready = (state_q == S_IDLE);
  assign bus_io.rd_data   = rd_data_q;
  assign bus_io.rd_valid  = rd_valid_q;
  assign bus_io.wr_ready  = wr_take;
  assign bus_io.done      = rd_last || (state_q == S_DONE);
  assign bus_io.error     = error_q;

endmodule

// File: tb/tb_ide_sector_engine.sv
// Directed bench for ide_sector_engine with a small behavioural drive model.
// Ports: none; summary line CHECKS/ERRORS at the end.
module tb_ide_sector_engine;
  localparam int NB = 512;
  localparam int PT = 16;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [23:0] cmd_lba = 24'd0;
  logic        rd_ready = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data;
  logic [7:0]  ide_din;

  ide_sector_engine_if bus_if();

  assign bus_if.cmd_valid = cmd_valid;
  assign bus_if.cmd_write = cmd_write;
  assign bus_if.cmd_lba   = cmd_lba;
  assign bus_if.rd_ready  = rd_ready;
  assign bus_if.wr_valid  = wr_valid;
  assign bus_if.wr_data   = wr_data;
  assign bus_if.ide_din   = ide_din;

  logic       cmd_ready, rd_valid, wr_ready, done, error;
  logic       ce_n, oe_n, we_n;
  logic [2:0] addr;
  logic [7:0] dout, rd_data;
  assign cmd_ready = bus_if.cmd_ready;
  assign rd_valid  = bus_if.rd_valid;
  assign rd_data   = bus_if.rd_data;
  assign wr_ready  = bus_if.wr_ready;
  assign done      = bus_if.done;
  assign error     = bus_if.error;
  assign ce_n      = bus_if.ide_ce_n;
  assign oe_n      = bus_if.ide_oe_n;
  assign we_n      = bus_if.ide_we_n;
  assign addr      = bus_if.ide_addr;
  assign dout      = bus_if.ide_dout;

  ide_sector_engine #(
    .SECTOR_BYTES(NB),
    .POLL_TIMEOUT(PT)
  ) u_dut (
    .clk   (clk),
    .arst  (arst),
    .bus_io(bus_if)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  // Drive model: reg0 returns a byte counter, reg7 returns BSY for bsy_n polls.
  bit         mclr = 1'b0;
  int         rptr = 0;
  int         polls = 0;
  int         widx = 0;
  int         bsy_n = 0;
  logic [7:0] stat_end = 8'h08;

  always_comb begin
    if (addr == 3'd7) ide_din = (polls < bsy_n) ? 8'h80 : stat_end;
    else ide_din = rptr[7:0];
  end
  assign wr_data = 8'hA5 ^ widx[7:0];

  always @(posedge clk) begin
    if (mclr) begin
      rptr  <= 0;
      polls <= 0;
      widx  <= 0;
    end else begin
      if (!ce_n && !oe_n && we_n && addr == 3'd0) rptr <= rptr + 1;
      if (!ce_n && !oe_n && we_n && addr == 3'd7) polls <= polls + 1;
      if (wr_ready) widx <= widx + 1;
    end
  end

  int tick = 0;
  int rd_pat = 0;
  bit wr_en = 1'b0;
  always @(posedge clk) begin
    #1;
    tick = tick + 1;
    rd_ready = (rd_pat == 0) || (tick % 3 == 0);
    wr_valid = wr_en && (tick % 4 != 3);
  end

  // Monitor, sampled mid-cycle.
  int n_w0, n_r0, n_poll, n_wrr, n_rdv, n_done, n_ev, n_rx;
  int bad_w, bad_rd, bad_done, bad_err, wn;
  int bad_both = 0;
  int bad_bus = 0;
  logic [10:0] wlog[8];
  bit prev_wrr, prev_poll, prev_done, prev_hold, mode_wr;
  logic [7:0] held;

  always @(negedge clk) begin
    if (mclr) begin
      n_w0 = 0; n_r0 = 0; n_poll = 0; n_wrr = 0; n_rdv = 0;
      n_done = 0; n_ev = 0; n_rx = 0; wn = 0;
      bad_w = 0; bad_rd = 0; bad_done = 0; bad_err = 0;
      prev_wrr = 0; prev_poll = 0; prev_done = 0; prev_hold = 0;
      for (int i = 0; i < 8; i++) wlog[i] = '0;
    end else begin
      if (!ce_n && !oe_n && !we_n) bad_bus++;
      if (!ce_n && !we_n && oe_n) begin
        if (addr == 3'd0) begin
          if (!wr_valid || dout != (8'hA5 ^ n_w0[7:0])) bad_w++;
          n_w0++;
        end else begin
          if (wn < 8) wlog[wn] = {addr, dout};
          wn++;
        end
      end
      if (!ce_n && !oe_n && we_n) begin
        if (addr == 3'd0) n_r0++;
        if (addr == 3'd7) n_poll++;
      end
      if (wr_ready) n_wrr++;
      if (rd_valid) n_rdv++;
      if (done && error) bad_both++;
      if (prev_done && !cmd_ready) bad_done++;
      if (done) begin
        n_done++;
        if (mode_wr ? !prev_wrr
                    : !(rd_valid && rd_ready && n_rx == NB - 1)) bad_done++;
      end
      if (error) begin
        n_ev++;
        if (!prev_poll) bad_err++;
      end
      if (rd_valid && prev_hold && rd_data != held) bad_rd++;
      if (rd_valid && rd_ready) begin
        if (rd_data != n_rx[7:0]) bad_rd++;
        n_rx++;
      end
      prev_hold = rd_valid && !rd_ready;
      held      = rd_data;
      prev_wrr  = wr_ready;
      prev_poll = !ce_n && !oe_n && we_n && addr == 3'd7;
      prev_done = done;
    end
  end

  task automatic clr();
    @(posedge clk);
    #1 mclr = 1'b1;
    @(posedge clk);
    #1 mclr = 1'b0;
  endtask

  task automatic cmd(input bit w, input logic [23:0] lba);
    @(posedge clk);
    #1;
    cmd_write = w;
    cmd_lba   = lba;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int k = 0;
    while (n_done + n_ev == 0 && k < budget) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk(tag, 32'(n_done + n_ev == 0), 32'd0);
    repeat (3) @(negedge clk);
    #2;
  endtask

  logic [10:0] exp1[6] = '{11'h201, 11'h323, 11'h401,
                           11'h500, 11'h6E0, 11'h720};
  logic [10:0] exp2[6] = '{11'h201, 11'h30A, 11'h400,
                           11'h500, 11'h6E0, 11'h730};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strb", 32'({ce_n, oe_n, we_n}), 32'h7);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_flags", 32'({rd_valid, wr_ready, done, error}), 32'd0);
    chk("rst_cmdrdy", 32'(cmd_ready), 32'd1);
    arst = 1'b0;

    // Read with three BSY polls first, consumer always ready.
    clr();
    mode_wr = 0; rd_pat = 0; bsy_n = 3; stat_end = 8'h08;
    cmd(1'b0, 24'h000123);
    repeat (3) @(negedge clk);
    #1 chk("busy_cmdrdy", 32'(cmd_ready), 32'd0);
    wait_end(3000, "rd1_timeout");
    chk("rd1_tfn", wn, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rd1_tf%0d", i), 32'(wlog[i]), 32'(exp1[i]));
    chk("rd1_polls", n_poll, 4);
    chk("rd1_rx", n_rx, NB);
    chk("rd1_bad", bad_rd, 0);
    chk("rd1_r0", n_r0, NB);
    chk("rd1_done", n_done, 1);
    chk("rd1_done_ok", bad_done, 0);
    chk("rd1_err", n_ev, 0);
    chk("rd1_wrr", n_wrr, 0);

    // Write with producer gaps.
    clr();
    mode_wr = 1; bsy_n = 0; stat_end = 8'h58; wr_en = 1'b1;
    cmd(1'b1, 24'h00000A);
    wait_end(3000, "wr_timeout");
    wr_en = 1'b0;
    chk("wr_tfn", wn, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("wr_tf%0d", i), 32'(wlog[i]), 32'(exp2[i]));
    chk("wr_w0", n_w0, NB);
    chk("wr_wrr", n_wrr, NB);
    chk("wr_bad", bad_w, 0);
    chk("wr_done", n_done, 1);
    chk("wr_done_ok", bad_done, 0);
    chk("wr_rdv", n_rdv, 0);
    chk("wr_err", n_ev, 0);

    // Read with consumer ready one cycle in three.
    clr();
    mode_wr = 0; rd_pat = 1; stat_end = 8'h08;
    cmd(1'b0, 24'h000777);
    wait_end(5000, "rd3_timeout");
    rd_pat = 0;
    chk("rd3_rx", n_rx, NB);
    chk("rd3_bad", bad_rd, 0);
    chk("rd3_r0", n_r0, NB);
    chk("rd3_done", n_done, 1);
    chk("rd3_done_ok", bad_done, 0);

    // Drive stays busy: poll timeout.
    clr();
    bsy_n = 1000;
    cmd(1'b0, 24'h000001);
    wait_end(500, "bsy_timeout");
    chk("bsy_polls", n_poll, PT);
    chk("bsy_err", n_ev, 1);
    chk("bsy_err_ok", bad_err, 0);
    chk("bsy_done", n_done, 0);
    chk("bsy_r0", n_r0 + n_w0, 0);
    chk("bsy_idle", 32'(cmd_ready), 32'd1);

    // ERR bit on first poll.
    clr();
    bsy_n = 0; stat_end = 8'h01;
    cmd(1'b0, 24'h000002);
    wait_end(500, "err_timeout");
    chk("err_polls", n_poll, 1);
    chk("err_err", n_ev, 1);
    chk("err_err_ok", bad_err, 0);
    chk("err_done", n_done, 0);

    // Reset in the middle of a read, then a fresh read.
    clr();
    stat_end = 8'h08; rd_pat = 0;
    cmd(1'b0, 24'h000055);
    for (int k = 0; k < 2000 && n_rx < 100; k++) begin
      @(negedge clk);
      #2;
    end
    chk("arst_reach", n_rx, 100);
    arst = 1'b1;
    #1;
    chk("arst_strb", 32'({ce_n, oe_n, we_n}), 32'h7);
    chk("arst_rdv", 32'(rd_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    clr();
    cmd(1'b0, 24'h000055);
    wait_end(3000, "arst2_timeout");
    chk("arst2_tf0", 32'(wlog[0]), 32'h201);
    chk("arst2_rx", n_rx, NB);
    chk("arst2_bad", bad_rd, 0);
    chk("arst2_done", n_done, 1);

    chk("both_hi", bad_both, 0);
    chk("bus_clash", bad_bus, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
